// File: rtl/apb4_completer_mem.sv
// APB4 completer backed by a word-addressed register memory, with programmable
// wait states, byte strobes and error responses for out-of-range or misaligned addresses.
module apb4_completer_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - 1 - OFFS;
  localparam int MEM_IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'((1 << OFFS) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  lat_write;
  logic [MEM_IW-1:0]     lat_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [STRB_W-1:0]     lat_strb;
  logic                  lat_err;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]      addr_idx;
  logic                  addr_err;
  logic [DATA_WIDTH-1:0] setup_rdata;
  logic [DATA_WIDTH-1:0] lat_rdata;
  logic                  unused_bits;

  // The address MSB belongs to the requester's completer select, so it is dropped here.
  assign addr_idx    = PADDR[ADDR_WIDTH-2:OFFS];
  assign addr_err    = (addr_idx >= IDX_W'(MEM_DEPTH)) || ((PADDR & OFFS_MASK) != '0);
  assign setup_rdata = (PWRITE || addr_err) ? '0 : mem[addr_idx[MEM_IW-1:0]];
  assign lat_rdata   = (lat_write || lat_err) ? '0 : mem[lat_idx];
  assign unused_bits = ^{PPROT, PADDR[ADDR_WIDTH-1]};

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
      lat_err   <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            lat_write <= PWRITE;
            lat_idx   <= addr_idx[MEM_IW-1:0];
            lat_wdata <= PWDATA;
            lat_strb  <= PSTRB;
            lat_err   <= addr_err;
            if (WAIT_CYCLES == 0) begin
              state   <= ST_RESP;
              PREADY  <= 1'b1;
              PSLVERR <= addr_err;
              PRDATA  <= setup_rdata;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            state   <= ST_RESP;
            PREADY  <= 1'b1;
            PSLVERR <= lat_err;
            PRDATA  <= lat_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Commit only if the requester is still in the access phase as PREADY is seen.
          state <= ST_IDLE;
          if (PSEL && PENABLE && lat_write && !lat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (lat_strb[b]) begin
                mem[lat_idx][b*8 +: 8] <= lat_wdata[b*8 +: 8];
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_completer_mem.sv
// Bench for apb4_completer_mem: three instances with 0, 1 and 3 wait states share
// one APB bus and are selected individually; responses are checked via a scoreboard queue.
module tb_apb4_completer_mem;

  logic        PCLK;
  logic        PRESET;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [31:0] prdata [3];

  int n_compared;
  int n_mismatched;
  int cur_dut;
  logic [31:0] cur_addr;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  typedef struct {
    int          dut;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  exp_t sb_q[$];
  int   wait_of [3];

  apb4_completer_mem #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb4_completer_mem #(.WAIT_CYCLES(1)) u_dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb4_completer_mem #(.WAIT_CYCLES(3)) u_dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s (dut %0d, addr %h): got %h expected %h", name, cur_dut, cur_addr, act, exp);
    end
  endtask

  task automatic checkOutput(input int d, input int waits, input bit got);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard_empty (dut %0d)", d);
      return;
    end
    e = sb_q.pop_front();
    compare("pready_seen", 32'(got), 32'd1);
    if (got) begin
      compare("wait_states", 32'(waits), 32'(e.waits));
      compare("pslverr", 32'(pslverr[d]), 32'(e.err));
      if (e.is_read) compare("prdata", prdata[d], e.data);
    end
  endtask

  // Entered and left just after a rising edge, so consecutive calls run back-to-back.
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    int   waits;
    bit   got;
    e.is_read = !wr;
    e.data    = exp_data;
    e.err     = exp_err;
    e.waits   = wait_of[d];
    sb_q.push_back(e);
    cur_dut  = d;
    cur_addr = addr;
    psel     = '0;
    psel[d]  = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = wdata;
    pstrb    = strb;
    @(negedge PCLK);
    compare("setup_pready", 32'(pready[d]), 32'd0);
    compare("setup_prdata", prdata[d], 32'd0);
    @(posedge PCLK); #1;
    penable = 1'b1;
    waits = 0;
    got   = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge PCLK);
      if (pready[d]) got = 1'b1;
      else begin
        waits++;
        @(posedge PCLK); #1;
      end
    end
    checkOutput(d, waits, got);
    @(posedge PCLK); #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    wait_of      = '{0, 1, 3};
    PRESET  = 1'b1;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = 3'b010;
    cur_dut = 0;
    cur_addr = '0;

    // dut, wr, addr, wdata, strb, expected read data, expected error
    vecs.push_back('{1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0008, 32'hDEADBEEF,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'hDEADBEEF,  1'b0});
    vecs.push_back('{1, 1'b0, 32'h8000_0008, 32'h0,         4'h0, 32'hDEADBEEF,  1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0004, 32'h11223344,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0004, 32'hAABBCCDD,  4'h5, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h11BB33DD,  1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0100, 32'h12345678,  4'hF, 32'h0,         1'b1});
    vecs.push_back('{1, 1'b1, 32'h0000_0006, 32'hCAFEF00D,  4'hF, 32'h0,         1'b1});
    vecs.push_back('{1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'h0,         1'b1});
    vecs.push_back('{1, 1'b0, 32'h0000_0006, 32'h0,         4'h0, 32'h0,         1'b1});
    vecs.push_back('{1, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h11BB33DD,  1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'h01010101,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0004, 32'h02020202,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0008, 32'h03030303,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_00FC, 32'h04040404,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h01010101,  1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h02020202,  1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'h03030303,  1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_00FC, 32'h0,         4'h0, 32'h04040404,  1'b0});
    vecs.push_back('{2, 1'b1, 32'h0000_0000, 32'hA1A1A1A1,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{2, 1'b1, 32'h0000_0004, 32'hB2B2B2B2,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{2, 1'b1, 32'h0000_0008, 32'hC3C3C3C3,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{2, 1'b1, 32'h0000_00FC, 32'hD4D4D4D4,  4'hF, 32'h0,         1'b0});
    vecs.push_back('{2, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hA1A1A1A1,  1'b0});
    vecs.push_back('{2, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hB2B2B2B2,  1'b0});
    vecs.push_back('{2, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'hC3C3C3C3,  1'b0});
    vecs.push_back('{2, 1'b0, 32'h0000_00FC, 32'h0,         4'h0, 32'hD4D4D4D4,  1'b0});

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int d = 0; d < 3; d++) begin
      cur_dut = d;
      compare("reset_pready", 32'(pready[d]), 32'd0);
      compare("reset_prdata", prdata[d], 32'd0);
      compare("reset_pslverr", 32'(pslverr[d]), 32'd0);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].strb, vecs[i].exp_data, vecs[i].exp_err);
    end

    // Reset lands in the wait cycle of a write to 0xC; the bus is held one more cycle.
    $display("[TB] reset during wait state");
    cur_dut  = 1;
    cur_addr = 32'h0000_000C;
    psel     = 3'b010;
    penable  = 1'b0;
    pwrite   = 1'b1;
    paddr    = 32'h0000_000C;
    pwdata   = 32'hFFFF_FFFF;
    pstrb    = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    PRESET  = 1'b1;
    @(negedge PCLK);
    compare("wait_pready", 32'(pready[1]), 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    compare("abort_pready", 32'(pready[1]), 32'd0);
    compare("abort_prdata", prdata[1], 32'd0);
    compare("abort_pslverr", 32'(pslverr[1]), 32'd0);
    @(posedge PCLK); #1;
    psel    = '0;
    penable = 1'b0;
    @(negedge PCLK);
    compare("orphan_enable_pready", 32'(pready[1]), 32'd0);
    @(posedge PCLK); #1;

    applyStimulus(1, 1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h0000_000C, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0);

    n_compared++;
    if (sb_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
